// File: rtl/scr1_mem_tb_wb.sv
// Behavioural dual-port Wishbone slave memory for the SCR1 Wishbone top-level bench.
// One shared byte array serves imem and dmem; dmem also reaches console and IRQ registers.
module scr1_mem_tb_wb #(
   parameter int SCR1_MEM_POWER_SIZE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ext_irq,
   output logic        soft_irq,
   input  logic [31:0] imem_req_ack_stall_in,
   input  logic [31:0] dmem_req_ack_stall_in,
   input  logic        wbd_imem_stb_i,
   input  logic [31:0] wbd_imem_adr_i,
   input  logic        wbd_imem_we_i,
   input  logic [31:0] wbd_imem_dat_i,
   input  logic [3:0]  wbd_imem_sel_i,
   output logic [31:0] wbd_imem_dat_o,
   output logic        wbd_imem_ack_o,
   output logic        wbd_imem_err_o,
   input  logic        wbd_dmem_stb_i,
   input  logic [31:0] wbd_dmem_adr_i,
   input  logic        wbd_dmem_we_i,
   input  logic [31:0] wbd_dmem_dat_i,
   input  logic [3:0]  wbd_dmem_sel_i,
   output logic [31:0] wbd_dmem_dat_o,
   output logic        wbd_dmem_ack_o,
   output logic        wbd_dmem_err_o
);

   localparam int AW        = SCR1_MEM_POWER_SIZE;
   localparam int MEM_BYTES = 2 ** AW;

   localparam logic [31:0] ADDR_CONSOLE  = 32'hF000_0000;
   localparam logic [31:0] ADDR_EXT_IRQ  = 32'hF000_0100;
   localparam logic [31:0] ADDR_SOFT_IRQ = 32'hF000_0200;

   logic [7:0] memory [0:MEM_BYTES-1];

   logic [31:0]   imem_stall_sr;
   logic [31:0]   dmem_stall_sr;
   logic          imem_fire;
   logic          dmem_fire;
   logic [AW-1:0] imem_base;
   logic [AW-1:0] dmem_base;
   logic [31:0]   imem_rdata;
   logic [31:0]   dmem_rdata;
   logic          dmem_is_console;
   logic          dmem_is_ext;
   logic          dmem_is_soft;
   logic          dmem_is_mmio;
   logic          unused_adr_bits;

   // Handshake: stb is held by the master until ack; a request is accepted on an edge where
   // stb=1, ack=0 and the stall bit is set, and ack is then high for exactly one cycle.
   assign imem_fire = rst_n & wbd_imem_stb_i & ~wbd_imem_ack_o & imem_stall_sr[0];
   assign dmem_fire = rst_n & wbd_dmem_stb_i & ~wbd_dmem_ack_o & dmem_stall_sr[0];

   assign imem_base = {wbd_imem_adr_i[AW-1:2], 2'b00};
   assign dmem_base = {wbd_dmem_adr_i[AW-1:2], 2'b00};

   assign dmem_is_console = (wbd_dmem_adr_i == ADDR_CONSOLE);
   assign dmem_is_ext     = (wbd_dmem_adr_i == ADDR_EXT_IRQ);
   assign dmem_is_soft    = (wbd_dmem_adr_i == ADDR_SOFT_IRQ);
   assign dmem_is_mmio    = dmem_is_console | dmem_is_ext | dmem_is_soft;

   assign imem_rdata = {memory[imem_base + AW'(3)], memory[imem_base + AW'(2)],
                        memory[imem_base + AW'(1)], memory[imem_base]};

   always_comb begin
      dmem_rdata = {memory[dmem_base + AW'(3)], memory[dmem_base + AW'(2)],
                    memory[dmem_base + AW'(1)], memory[dmem_base]};
      if (dmem_is_console) dmem_rdata = 32'h0;
      if (dmem_is_ext)     dmem_rdata = {31'h0, ext_irq};
      if (dmem_is_soft)    dmem_rdata = {31'h0, soft_irq};
   end

   assign wbd_imem_err_o = 1'b0;
   assign wbd_dmem_err_o = 1'b0;

   // Address bits outside the word index only alias, except the full dmem compare above.
   assign unused_adr_bits = ^{wbd_imem_adr_i[31:AW], wbd_imem_adr_i[1:0], wbd_dmem_adr_i[1:0]};

   // A zero pattern means "never stall"; the pattern is captured for the whole reset period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_stall_sr <= (imem_req_ack_stall_in == 32'h0) ? 32'hFFFF_FFFF : imem_req_ack_stall_in;
         dmem_stall_sr <= (dmem_req_ack_stall_in == 32'h0) ? 32'hFFFF_FFFF : dmem_req_ack_stall_in;
      end else begin
         imem_stall_sr <= {imem_stall_sr[0], imem_stall_sr[31:1]};
         dmem_stall_sr <= {dmem_stall_sr[0], dmem_stall_sr[31:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbd_imem_ack_o <= 1'b0;
         wbd_imem_dat_o <= 32'h0;
      end else begin
         wbd_imem_ack_o <= imem_fire;
         if (imem_fire) wbd_imem_dat_o <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbd_dmem_ack_o <= 1'b0;
         wbd_dmem_dat_o <= 32'h0;
      end else begin
         wbd_dmem_ack_o <= dmem_fire;
         if (dmem_fire) wbd_dmem_dat_o <= dmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_irq  <= 1'b0;
         soft_irq <= 1'b0;
      end else if (dmem_fire && wbd_dmem_we_i) begin
         if (dmem_is_ext)  ext_irq  <= wbd_dmem_dat_i[0];
         if (dmem_is_soft) soft_irq <= wbd_dmem_dat_i[0];
      end
   end

   always_ff @(posedge clk) begin
      if (dmem_fire && wbd_dmem_we_i && dmem_is_console) $write("%c", wbd_dmem_dat_i[7:0]);
   end

   // Storage has no reset. The dmem write is applied after imem so it wins a same-byte clash;
   // reads in the same cycle see the old contents through the non-blocking update.
   always_ff @(posedge clk) begin
      if (imem_fire && wbd_imem_we_i) begin
         for (int i = 0; i < 4; i++)
            if (wbd_imem_sel_i[i]) memory[imem_base + AW'(i)] <= wbd_imem_dat_i[8*i +: 8];
      end
      if (dmem_fire && wbd_dmem_we_i && !dmem_is_mmio) begin
         for (int i = 0; i < 4; i++)
            if (wbd_dmem_sel_i[i]) memory[dmem_base + AW'(i)] <= wbd_dmem_dat_i[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_scr1_mem_tb_wb.sv
// Directed bench for scr1_mem_tb_wb: drivers push expected read data, a negedge monitor
// pops and compares whenever a port acks.
module tb_scr1_mem_tb_wb;

   localparam int P = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ext_irq, soft_irq;
   logic [31:0] imem_req_ack_stall_in, dmem_req_ack_stall_in;
   logic        wbd_imem_stb_i, wbd_imem_we_i;
   logic [31:0] wbd_imem_adr_i, wbd_imem_dat_i;
   logic [3:0]  wbd_imem_sel_i;
   logic [31:0] wbd_imem_dat_o;
   logic        wbd_imem_ack_o, wbd_imem_err_o;
   logic        wbd_dmem_stb_i, wbd_dmem_we_i;
   logic [31:0] wbd_dmem_adr_i, wbd_dmem_dat_i;
   logic [3:0]  wbd_dmem_sel_i;
   logic [31:0] wbd_dmem_dat_o;
   logic        wbd_dmem_ack_o, wbd_dmem_err_o;

   int checks = 0;
   int errors = 0;

   // bit 32 set = compare read data on this ack
   logic [32:0] imem_q[$];
   logic [32:0] dmem_q[$];
   logic [32:0] mon_ie, mon_de;

   scr1_mem_tb_wb #(.SCR1_MEM_POWER_SIZE(P)) dut (
      .clk(clk), .rst_n(rst_n), .ext_irq(ext_irq), .soft_irq(soft_irq),
      .imem_req_ack_stall_in(imem_req_ack_stall_in),
      .dmem_req_ack_stall_in(dmem_req_ack_stall_in),
      .wbd_imem_stb_i(wbd_imem_stb_i), .wbd_imem_adr_i(wbd_imem_adr_i),
      .wbd_imem_we_i(wbd_imem_we_i), .wbd_imem_dat_i(wbd_imem_dat_i),
      .wbd_imem_sel_i(wbd_imem_sel_i), .wbd_imem_dat_o(wbd_imem_dat_o),
      .wbd_imem_ack_o(wbd_imem_ack_o), .wbd_imem_err_o(wbd_imem_err_o),
      .wbd_dmem_stb_i(wbd_dmem_stb_i), .wbd_dmem_adr_i(wbd_dmem_adr_i),
      .wbd_dmem_we_i(wbd_dmem_we_i), .wbd_dmem_dat_i(wbd_dmem_dat_i),
      .wbd_dmem_sel_i(wbd_dmem_sel_i), .wbd_dmem_dat_o(wbd_dmem_dat_o),
      .wbd_dmem_ack_o(wbd_dmem_ack_o), .wbd_dmem_err_o(wbd_dmem_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && wbd_imem_ack_o) begin
         if (imem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL imem_unexpected_ack: got ack=1 expected no ack");
         end else begin
            mon_ie = imem_q.pop_front();
            if (mon_ie[32]) check("imem_rdata", wbd_imem_dat_o, mon_ie[31:0]);
         end
      end
      if (rst_n && wbd_dmem_ack_o) begin
         if (dmem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dmem_unexpected_ack: got ack=1 expected no ack");
         end else begin
            mon_de = dmem_q.pop_front();
            if (mon_de[32]) check("dmem_rdata", wbd_dmem_dat_o, mon_de[31:0]);
         end
      end
   end

   task automatic imem_read(input logic [31:0] adr, input logic [31:0] exp);
      int lat;
      wbd_imem_stb_i = 1'b1; wbd_imem_adr_i = adr; wbd_imem_we_i = 1'b0; wbd_imem_sel_i = 4'hF;
      imem_q.push_back({1'b1, exp});
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!wbd_imem_ack_o && lat < 64);
      if (!wbd_imem_ack_o) begin
         checks++; errors++;
         $display("FAIL imem_timeout: got no ack after %0d cycles expected ack", lat);
      end else check("imem_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check("imem_single_ack", {31'h0, wbd_imem_ack_o}, 32'h0);
      wbd_imem_stb_i = 1'b0;
   endtask

   task automatic dmem_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic chk, input logic [31:0] exp);
      int lat;
      wbd_dmem_stb_i = 1'b1; wbd_dmem_adr_i = adr; wbd_dmem_we_i = we;
      wbd_dmem_dat_i = dat; wbd_dmem_sel_i = sel;
      dmem_q.push_back({chk, exp});
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!wbd_dmem_ack_o && lat < 64);
      if (!wbd_dmem_ack_o) begin
         checks++; errors++;
         $display("FAIL dmem_timeout: got no ack after %0d cycles expected ack", lat);
      end else check("dmem_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check("dmem_single_ack", {31'h0, wbd_dmem_ack_o}, 32'h0);
      wbd_dmem_stb_i = 1'b0; wbd_dmem_we_i = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] istall, input logic [31:0] dstall);
      rst_n = 1'b0;
      imem_req_ack_stall_in = istall; dmem_req_ack_stall_in = dstall;
      wbd_imem_stb_i = 1'b0; wbd_dmem_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int iack_cyc, dack_cyc, iacks, dacks;
      imem_req_ack_stall_in = 32'h0; dmem_req_ack_stall_in = 32'h0;
      wbd_imem_stb_i = 1'b0; wbd_imem_adr_i = 32'h0; wbd_imem_we_i = 1'b0;
      wbd_imem_dat_i = 32'h0; wbd_imem_sel_i = 4'h0;
      wbd_dmem_stb_i = 1'b0; wbd_dmem_adr_i = 32'h0; wbd_dmem_we_i = 1'b0;
      wbd_dmem_dat_i = 32'h0; wbd_dmem_sel_i = 4'h0;

      for (int a = 0; a < 1024; a++) dut.memory[a] = 8'h00;
      dut.memory[32'h100] = 8'h11; dut.memory[32'h101] = 8'h22;
      dut.memory[32'h102] = 8'h33; dut.memory[32'h103] = 8'h44;
      dut.memory[32'h000] = 8'hEF; dut.memory[32'h001] = 8'hBE;
      dut.memory[32'h002] = 8'hAD; dut.memory[32'h003] = 8'hDE;
      dut.memory[32'h300] = 8'h04; dut.memory[32'h301] = 8'h03;
      dut.memory[32'h302] = 8'h02; dut.memory[32'h303] = 8'h01;

      // reset state
      repeat (2) @(posedge clk); #1;
      check("rst_imem_ack", {31'h0, wbd_imem_ack_o}, 32'h0);
      check("rst_dmem_ack", {31'h0, wbd_dmem_ack_o}, 32'h0);
      check("rst_imem_dat", wbd_imem_dat_o, 32'h0);
      check("rst_dmem_dat", wbd_dmem_dat_o, 32'h0);
      check("rst_irqs", {30'h0, ext_irq, soft_irq}, 32'h0);
      check("err_const", {30'h0, wbd_imem_err_o, wbd_dmem_err_o}, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // preloaded read, partial-byte write then read
      imem_read(32'h0000_0100, 32'h4433_2211);
      dmem_xfer(1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
      dmem_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b1, 32'h00BB_00DD);

      // irq registers
      dmem_xfer(1'b1, 32'hF000_0100, 32'h1, 4'hF, 1'b0, 32'h0);
      check("ext_irq_set", {31'h0, ext_irq}, 32'h1);
      dmem_xfer(1'b1, 32'hF000_0100, 32'h0, 4'hF, 1'b0, 32'h0);
      check("ext_irq_clr", {31'h0, ext_irq}, 32'h0);
      dmem_xfer(1'b1, 32'hF000_0200, 32'h1, 4'hF, 1'b0, 32'h0);
      check("soft_irq_set", {31'h0, soft_irq}, 32'h1);
      dmem_xfer(1'b0, 32'hF000_0200, 32'h0, 4'hF, 1'b1, 32'h1);
      dmem_xfer(1'b0, 32'hF000_0100, 32'h0, 4'hF, 1'b1, 32'h0);

      // console, then newline so the summary starts on its own line
      dmem_xfer(1'b1, 32'hF000_0000, 32'h41, 4'hF, 1'b0, 32'h0);
      dmem_xfer(1'b1, 32'hF000_0000, 32'h0A, 4'hF, 1'b0, 32'h0);
      dmem_xfer(1'b0, 32'hF000_0000, 32'h0, 4'hF, 1'b1, 32'h0);
      imem_read(32'h0000_0000, 32'hDEAD_BEEF);

      // address aliasing above the array size
      imem_read(32'h0001_0100, 32'h4433_2211);
      dmem_xfer(1'b0, 32'hFFFF_0102, 32'h0, 4'hF, 1'b1, 32'h4433_2211);

      // same-word simultaneous access: imem sees pre-write data
      fork
         imem_read(32'h0000_0300, 32'h0102_0304);
         dmem_xfer(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
      join
      imem_read(32'h0000_0300, 32'hCAFE_F00D);

      // stall patterns, stb held from reset release
      rst_n = 1'b0;
      imem_req_ack_stall_in = 32'h0000_0002; dmem_req_ack_stall_in = 32'h0000_0004;
      wbd_imem_stb_i = 1'b1; wbd_imem_adr_i = 32'h0; wbd_imem_we_i = 1'b0;
      wbd_dmem_stb_i = 1'b1; wbd_dmem_adr_i = 32'h100; wbd_dmem_we_i = 1'b0;
      imem_q.push_back({1'b1, 32'hDEAD_BEEF});
      dmem_q.push_back({1'b1, 32'h4433_2211});
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      iack_cyc = 0; dack_cyc = 0; iacks = 0; dacks = 0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk); #1;
         if (wbd_imem_ack_o) begin iacks++; if (iack_cyc == 0) iack_cyc = cyc; end
         if (wbd_dmem_ack_o) begin dacks++; if (dack_cyc == 0) dack_cyc = cyc; end
      end
      wbd_imem_stb_i = 1'b0; wbd_dmem_stb_i = 1'b0;
      check("imem_stall_ack_cycle", 32'(iack_cyc), 32'd2);
      check("dmem_stall_ack_cycle", 32'(dack_cyc), 32'd3);
      check("imem_stall_ack_count", 32'(iacks), 32'd1);
      check("dmem_stall_ack_count", 32'(dacks), 32'd1);

      // reset in the middle of a transfer
      do_reset(32'h0, 32'h0);
      dmem_xfer(1'b1, 32'hF000_0100, 32'h1, 4'hF, 1'b0, 32'h0);
      dmem_xfer(1'b1, 32'hF000_0200, 32'h1, 4'hF, 1'b0, 32'h0);
      wbd_imem_stb_i = 1'b1; wbd_imem_adr_i = 32'h100;
      @(posedge clk); #1;
      check("pre_reset_ack", {31'h0, wbd_imem_ack_o}, 32'h1);
      check("pre_reset_irqs", {30'h0, ext_irq, soft_irq}, 32'h3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack", {31'h0, wbd_imem_ack_o}, 32'h0);
      check("mid_rst_dat", wbd_imem_dat_o, 32'h0);
      check("mid_rst_irqs", {30'h0, ext_irq, soft_irq}, 32'h0);
      wbd_imem_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      imem_read(32'h0000_0100, 32'h4433_2211);
      dmem_xfer(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b1, 32'h00BB_00DD);
      imem_read(32'h0000_0300, 32'hCAFE_F00D);

      repeat (3) @(posedge clk);
      check("imem_q_drained", 32'(imem_q.size()), 32'd0);
      check("dmem_q_drained", 32'(dmem_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
